imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
Registered decode-stage front end. It classifies each fetched instruction's format from its opcode (no external type select) and generates the XLEN-wide immediate, including shift-amount handling. It also computes the PC-relative target and flags illegal opcodes. Sits between the fetch buffer and register-read, with valid/ready handshakes on both sides and a pipeline flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; also sets the width of pc, imm and target.
CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill the held entry and block acceptance this cycle
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  registered entry valid
out_ready  in  1  downstream accepts
out_instr  out  32  registered instruction
out_pc  out  XLEN  registered pc
out_fmt  out  3  0=I 1=S 2=B 3=U 4=J 5=R 7=illegal
out_imm  out  XLEN  generated immediate
out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN
out_illegal  out  1  opcode not recognised
illegal_cnt  out  CNT_W  count of accepted illegal instructions, saturating

Behaviour:
- Reset (async, rst_n=0): out_valid=0. out_instr, out_pc, out_imm and out_target=0. out_fmt=0, out_illegal=0, illegal_cnt=0. All take effect immediately, regardless of clk.
- in_ready = !flush && (!out_valid || out_ready). Purely combinational; no combinational path from in_valid to in_ready.
- Accept = in_valid && in_ready. On accept, all out_* registers load the decoded result of the input on the next edge; out_valid=1. Latency is 1 cycle.
- No accept and out_ready=1: out_valid<=0.
- No accept and out_ready=0: all outputs hold, bit-stable (stall).
- Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1): new entry replaces the old one with no bubble, giving full throughput.
- flush=1: out_valid<=0 on the next edge. Flush overrides accept; the input that cycle is dropped and illegal_cnt is unchanged. Data registers may hold stale values.
- Format decode on in_instr[6:0]:
  - I: 0000011, 0010011, 1100111, 1110011; with XLEN=64 also 0011011.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - R: 0110011; with XLEN=64 also 0111011.
  - Anything else: illegal.
- Immediates are sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}; sign-extended when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and illegal: 0.
- Shift immediates (opcode 0010011 with funct3 001 or 101, or 0011011 with those funct3): imm = shamt zero-extended.
  - shamt = instr[24:20] for XLEN=32 and for opcode 0011011.
  - shamt = instr[25:20] for XLEN=64 with opcode 0010011.
  - funct7 bits are excluded from imm.
- out_target is computed combinationally before the register and registered with the entry. It is produced for every format; consumers use it for B/J/AUIPC only.
- illegal_cnt increments by 1 on each accept whose opcode is illegal. It saturates at 2^CNT_W-1 and is cleared only by reset.
- Reset mid-stall: entry lost, out_valid=0, in_ready=1 after release (when flush=0).

Test Plan:
1. XLEN=32, accept 0x00A00093 (addi x1,x0,10), pc=0x0 -> next cycle out_valid=1, fmt=0, imm=0x0000000A, illegal=0.
2. Back-to-back with out_ready=1, one word per cycle:
   - 0xFE20AE23 (sw), pc=0x4 -> fmt=1, imm=0xFFFFFFFC.
   - 0xFE000CE3 (beq -8), pc=0x100 -> fmt=2, imm=0xFFFFFFF8, target=0x000000F8.
   - 0x001000EF (jal +2048), pc=0x0 -> fmt=4, imm=0x00000800, target=0x00000800.
   - No bubbles; in_ready stays 1.
3. Shift handling, XLEN=32: 0x4030D093 (srai x1,x1,3) -> fmt=0, imm=0x00000003, not 0x00000403.
4. XLEN=64: 0x800002B7 (lui x5,0x80000) -> fmt=3, imm=0xFFFFFFFF80000000.
5. Stall, then flush:
   - Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs bit-stable.
   - Assert flush -> out_valid=0 next cycle, new input dropped, illegal_cnt unchanged.
6. Illegal counting and reset:
   - Accept 0x0000007F three times -> each fmt=7, illegal=1, imm=0; illegal_cnt=3.
   - With CNT_W=2, five accepts -> saturates at 3.
   - Drop rst_n mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/imm_decode_stage_if.sv
// Handshake and data bundle between the fetch buffer, the decode front end and register-read.
// The master side drives the upstream entry and the downstream ready; the slave side is the decode stage.
interface imm_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [XLEN-1:0]  out_pc;
  logic [2:0]       out_fmt;
  logic [XLEN-1:0]  out_imm;
  logic [XLEN-1:0]  out_target;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_fmt, out_imm,
           out_target, out_illegal, illegal_cnt
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_fmt, out_imm,
           out_target, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered decode front end: classifies the instruction format from its opcode, builds the
// XLEN-wide immediate (with shift-amount handling), the PC-relative target and an illegal flag.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  imm_decode_stage_if.slave  bus
);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_R = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic             w_shift_f3;
  logic [2:0]       w_fmt;
  logic             w_shift;
  logic             w_illegal;
  logic [5:0]       w_shamt;
  logic [31:0]      w_raw;
  logic [XLEN-1:0]  w_imm;
  logic [XLEN-1:0]  w_target;
  logic             w_accept;

  logic             r_valid;
  logic [31:0]      r_instr;
  logic [XLEN-1:0]  r_pc;
  logic [2:0]       r_fmt;
  logic [XLEN-1:0]  r_imm;
  logic [XLEN-1:0]  r_target;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  // Handshake: an entry moves on a cycle where valid && ready on that side. in_ready depends only
  // on flush, the held valid and out_ready, so the stage can drain and refill in the same cycle.
  assign bus.in_ready = !bus.flush && (!r_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;

  assign w_opcode   = bus.in_instr[6:0];
  assign w_funct3   = bus.in_instr[14:12];
  assign w_shift_f3 = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  always_comb begin
    w_fmt   = FMT_X;
    w_shift = 1'b0;
    case (w_opcode)
      7'b0000011, 7'b1100111, 7'b1110011: w_fmt = FMT_I;
      7'b0010011: begin
        w_fmt   = FMT_I;
        w_shift = w_shift_f3;
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          w_fmt   = FMT_I;
          w_shift = w_shift_f3;
        end
      end
      7'b0100011:             w_fmt = FMT_S;
      7'b1100011:             w_fmt = FMT_B;
      7'b0110111, 7'b0010111: w_fmt = FMT_U;
      7'b1101111:             w_fmt = FMT_J;
      7'b0110011:             w_fmt = FMT_R;
      7'b0111011: begin
        if (XLEN == 64) w_fmt = FMT_R;
      end
      default: ;
    endcase
  end

  assign w_illegal = (w_fmt == FMT_X);

  // The word-sized shifts (0011011) only ever carry a 5-bit shamt, even on a 64-bit datapath.
  assign w_shamt = ((XLEN == 64) && (w_opcode == 7'b0010011)) ? bus.in_instr[25:20]
                                                              : {1'b0, bus.in_instr[24:20]};

  always_comb begin
    w_raw = 32'd0;
    case (w_fmt)
      FMT_I: w_raw = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      FMT_S: w_raw = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      FMT_B: w_raw = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                      bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
      FMT_U: w_raw = {bus.in_instr[31:12], 12'd0};
      FMT_J: w_raw = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                      bus.in_instr[20], bus.in_instr[30:21], 1'b0};
      default: w_raw = 32'd0;
    endcase
  end

  assign w_imm    = w_shift ? XLEN'(w_shamt) : XLEN'($signed(w_raw));
  assign w_target = bus.in_pc + w_imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_pc      <= '0;
      r_fmt     <= '0;
      r_imm     <= '0;
      r_target  <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (bus.flush)          r_valid <= 1'b0;
      else if (w_accept)      r_valid <= 1'b1;
      else if (bus.out_ready) r_valid <= 1'b0;

      if (w_accept) begin
        r_instr   <= bus.in_instr;
        r_pc      <= bus.in_pc;
        r_fmt     <= w_fmt;
        r_imm     <= w_imm;
        r_target  <= w_target;
        r_illegal <= w_illegal;
      end

      if (w_accept && w_illegal && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid   = r_valid;
  assign bus.out_instr   = r_instr;
  assign bus.out_pc      = r_pc;
  assign bus.out_fmt     = r_fmt;
  assign bus.out_imm     = r_imm;
  assign bus.out_target  = r_target;
  assign bus.out_illegal = r_illegal;
  assign bus.illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed cases plus randomized traffic against a queue-based model,
// on a 32-bit instance, a 64-bit instance and a 32-bit instance with a 2-bit illegal counter.
module tb_imm_decode_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [63:0] target;
    logic        illegal;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32), .CNT_W(16)) bus32 ();
  imm_decode_stage_if #(.XLEN(64), .CNT_W(16)) bus64 ();
  imm_decode_stage_if #(.XLEN(32), .CNT_W(2))  bus_sat ();

  imm_decode_stage #(.XLEN(32), .CNT_W(16)) dut32    (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  imm_decode_stage #(.XLEN(64), .CNT_W(16)) dut64    (.clk(clk), .rst_n(rst_n), .bus(bus64.slave));
  imm_decode_stage #(.XLEN(32), .CNT_W(2))  dut_sat  (.clk(clk), .rst_n(rst_n), .bus(bus_sat.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard state ----------------
  ent_t        exp_q32[$];
  ent_t        exp_q64[$];
  logic [15:0] exp_cnt32;
  logic [15:0] exp_cnt64;

  logic [6:0] op_tab [12] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0011011,
                              7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                              7'b0110011, 7'b0111011};

  // ---------------- reference model ----------------
  function automatic ent_t model(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
    ent_t        e;
    longint      off;
    logic [63:0] mask;
    logic        is_shift;
    mask     = (xlen == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    is_shift = (ins[14:12] == 3'b001) || (ins[14:12] == 3'b101);
    off      = 0;
    e.fmt    = 3'd7;
    case (ins[6:0])
      7'b0000011, 7'b1100111, 7'b1110011: begin
        e.fmt = 3'd0; off = longint'($signed(ins[31:20]));
      end
      7'b0010011: begin
        e.fmt = 3'd0;
        if (is_shift) off = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
        else          off = longint'($signed(ins[31:20]));
      end
      7'b0011011: if (xlen == 64) begin
        e.fmt = 3'd0;
        if (is_shift) off = longint'(ins[24:20]);
        else          off = longint'($signed(ins[31:20]));
      end
      7'b0100011: begin e.fmt = 3'd1; off = longint'($signed({ins[31:25], ins[11:7]})); end
      7'b1100011: begin
        e.fmt = 3'd2; off = 2 * longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]}));
      end
      7'b0110111, 7'b0010111: begin e.fmt = 3'd3; off = longint'($signed(ins[31:12])) * 4096; end
      7'b1101111: begin
        e.fmt = 3'd4; off = 2 * longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]}));
      end
      7'b0110011: e.fmt = 3'd5;
      7'b0111011: if (xlen == 64) e.fmt = 3'd5;
      default: ;
    endcase
    e.instr   = ins;
    e.pc      = pc & mask;
    e.illegal = (e.fmt == 3'd7);
    e.imm     = 64'(off) & mask;
    e.target  = (pc + 64'(off)) & mask;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    if ($urandom_range(0, 5) != 0) ins[6:0] = op_tab[$urandom_range(0, 11)];
    return ins;
  endfunction

  function automatic ent_t obs32();
    ent_t e;
    e.instr   = bus32.out_instr;
    e.pc      = {32'd0, bus32.out_pc};
    e.fmt     = bus32.out_fmt;
    e.imm     = {32'd0, bus32.out_imm};
    e.target  = {32'd0, bus32.out_target};
    e.illegal = bus32.out_illegal;
    return e;
  endfunction

  function automatic ent_t obs64();
    ent_t e;
    e.instr   = bus64.out_instr;
    e.pc      = bus64.out_pc;
    e.fmt     = bus64.out_fmt;
    e.imm     = bus64.out_imm;
    e.target  = bus64.out_target;
    e.illegal = bus64.out_illegal;
    return e;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive32(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
    bus32.in_valid = v; bus32.in_instr = ins; bus32.in_pc = pc;
    bus32.out_ready = ordy; bus32.flush = fl;
  endtask

  task automatic drive64(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic ordy, input logic fl);
    bus64.in_valid = v; bus64.in_instr = ins; bus64.in_pc = pc;
    bus64.out_ready = ordy; bus64.flush = fl;
  endtask

  task automatic drive_sat(input logic v, input logic [31:0] ins, input logic ordy);
    bus_sat.in_valid = v; bus_sat.in_instr = ins; bus_sat.in_pc = 32'h0;
    bus_sat.out_ready = ordy; bus_sat.flush = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if (obs32() !== '0 || bus32.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset32 obs=%h valid=%b exp=0", obs32(), bus32.out_valid);
    end
    n_checks++;
    if (obs64() !== '0 || bus64.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset64 obs=%h valid=%b exp=0", obs64(), bus64.out_valid);
    end
    n_checks++;
    if ({bus32.illegal_cnt, bus64.illegal_cnt, bus_sat.illegal_cnt} !== 34'd0) begin
      n_fail++; $display("FAIL reset_cnt got=%h/%h/%h exp=0", bus32.illegal_cnt,
                         bus64.illegal_cnt, bus_sat.illegal_cnt);
    end
    n_checks++;
    if (bus32.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus32.in_ready);
    end
  endtask

  task automatic test_addi();
    drive32(1'b1, 32'h00A00093, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    drive32(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if ({bus32.out_valid, bus32.out_fmt, bus32.out_imm, bus32.out_target, bus32.out_illegal}
        !== {1'b1, 3'd0, 32'h0000000A, 32'h0000000A, 1'b0}) begin
      n_fail++; $display("FAIL addi got v=%b fmt=%0d imm=%h tgt=%h ill=%b exp v=1 fmt=0 imm=0000000a",
                         bus32.out_valid, bus32.out_fmt, bus32.out_imm, bus32.out_target,
                         bus32.out_illegal);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins_t [3] = '{32'hFE20AE23, 32'hFE000CE3, 32'h001000EF};
    logic [31:0] pc_t  [3] = '{32'h4, 32'h100, 32'h0};
    logic [2:0]  fmt_t [3] = '{3'd1, 3'd2, 3'd4};
    logic [31:0] imm_t [3] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800};
    logic [31:0] tgt_t [3] = '{32'h00000000, 32'h000000F8, 32'h00000800};
    for (int i = 0; i < 3; i++) begin
      drive32(1'b1, ins_t[i], pc_t[i], 1'b1, 1'b0);
      #1;
      n_checks++;
      if (bus32.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, bus32.in_ready);
      end
      @(negedge clk);
      n_checks++;
      if ({bus32.out_valid, bus32.out_fmt, bus32.out_imm, bus32.out_target}
          !== {1'b1, fmt_t[i], imm_t[i], tgt_t[i]}) begin
        n_fail++; $display("FAIL b2b[%0d] got v=%b fmt=%0d imm=%h tgt=%h exp v=1 fmt=%0d imm=%h tgt=%h",
                           i, bus32.out_valid, bus32.out_fmt, bus32.out_imm, bus32.out_target,
                           fmt_t[i], imm_t[i], tgt_t[i]);
      end
    end
    drive32(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_shift();
    drive32(1'b1, 32'h4030D093, 32'h10, 1'b1, 1'b0);
    @(negedge clk);
    drive32(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if ({bus32.out_valid, bus32.out_fmt, bus32.out_imm} !== {1'b1, 3'd0, 32'h00000003}) begin
      n_fail++; $display("FAIL srai got v=%b fmt=%0d imm=%h exp v=1 fmt=0 imm=00000003",
                         bus32.out_valid, bus32.out_fmt, bus32.out_imm);
    end
    @(negedge clk);
  endtask

  task automatic test_stall_flush();
    ent_t e;
    e = model(32'h123450B7, 64'h40, 32);
    drive32(1'b1, 32'h123450B7, 32'h40, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive32(1'b1, 32'h00A00093, 32'h80, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (bus32.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, bus32.in_ready);
      end
      n_checks++;
      if (bus32.out_valid !== 1'b1 || obs32() !== e) begin
        n_fail++; $display("FAIL stall_hold[%0d] v=%b got=%h exp=%h", i, bus32.out_valid, obs32(), e);
      end
      @(negedge clk);
    end
    drive32(1'b1, 32'h0000007F, 32'h80, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (bus32.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready got=%b exp=0", bus32.in_ready);
    end
    @(negedge clk);
    drive32(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if (bus32.out_valid !== 1'b0 || bus32.illegal_cnt !== exp_cnt32) begin
      n_fail++; $display("FAIL flush got v=%b cnt=%0d exp v=0 cnt=%0d",
                         bus32.out_valid, bus32.illegal_cnt, exp_cnt32);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 3; i++) begin
      drive32(1'b1, 32'h0000007F, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      if (exp_cnt32 != 16'hFFFF) exp_cnt32++;
      @(negedge clk);
      n_checks++;
      if ({bus32.out_valid, bus32.out_fmt, bus32.out_illegal, bus32.out_imm, bus32.illegal_cnt}
          !== {1'b1, 3'd7, 1'b1, 32'h0, exp_cnt32}) begin
        n_fail++; $display("FAIL illegal[%0d] got v=%b fmt=%0d ill=%b imm=%h cnt=%0d exp fmt=7 ill=1 imm=0 cnt=%0d",
                           i, bus32.out_valid, bus32.out_fmt, bus32.out_illegal, bus32.out_imm,
                           bus32.illegal_cnt, exp_cnt32);
      end
    end
    drive32(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random32(input int cycles);
    ent_t        e;
    logic        v, ordy, fl, exp_rdy;
    logic [31:0] ins, pc;
    for (int c = 0; c < cycles; c++) begin
      n_checks++;
      if (bus32.out_valid !== (exp_q32.size() != 0)) begin
        n_fail++; $display("FAIL rnd32_valid cyc=%0d got=%b exp=%b", c, bus32.out_valid, exp_q32.size() != 0);
      end else if (exp_q32.size() != 0) begin
        n_checks++;
        if (obs32() !== exp_q32[0]) begin
          n_fail++; $display("FAIL rnd32_entry cyc=%0d got=%h exp=%h", c, obs32(), exp_q32[0]);
        end
      end
      n_checks++;
      if (bus32.illegal_cnt !== exp_cnt32) begin
        n_fail++; $display("FAIL rnd32_cnt cyc=%0d got=%0d exp=%0d", c, bus32.illegal_cnt, exp_cnt32);
      end
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 9) == 0);
      ins  = rand_instr();
      pc   = $urandom;
      drive32(v, ins, pc, ordy, fl);
      #1;
      exp_rdy = !fl && ((exp_q32.size() == 0) || ordy);
      n_checks++;
      if (bus32.in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rnd32_ready cyc=%0d got=%b exp=%b", c, bus32.in_ready, exp_rdy);
      end
      if (fl) exp_q32.delete();
      else if (v && exp_rdy) begin
        e = model(ins, {32'd0, pc}, 32);
        exp_q32.delete();
        exp_q32.push_back(e);
        if (e.illegal && exp_cnt32 != 16'hFFFF) exp_cnt32++;
      end else if (ordy) exp_q32.delete();
      @(negedge clk);
    end
    drive32(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    exp_q32.delete();
  endtask

  task automatic test_xlen64();
    logic [31:0] ins_t [3] = '{32'h800002B7, 32'h02009093, 32'h0200909B};
    logic [2:0]  fmt_t [3] = '{3'd3, 3'd0, 3'd0};
    logic [63:0] imm_t [3] = '{64'hFFFFFFFF80000000, 64'h20, 64'h0};
    for (int i = 0; i < 3; i++) begin
      drive64(1'b1, ins_t[i], 64'h1000, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++;
      if ({bus64.out_valid, bus64.out_fmt, bus64.out_imm, bus64.out_target}
          !== {1'b1, fmt_t[i], imm_t[i], imm_t[i] + 64'h1000}) begin
        n_fail++; $display("FAIL x64[%0d] got v=%b fmt=%0d imm=%h tgt=%h exp fmt=%0d imm=%h",
                           i, bus64.out_valid, bus64.out_fmt, bus64.out_imm, bus64.out_target,
                           fmt_t[i], imm_t[i]);
      end
    end
    drive64(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random64(input int cycles);
    ent_t        e;
    logic        v, ordy, fl, exp_rdy;
    logic [31:0] ins;
    logic [63:0] pc;
    for (int c = 0; c < cycles; c++) begin
      n_checks++;
      if (bus64.out_valid !== (exp_q64.size() != 0)) begin
        n_fail++; $display("FAIL rnd64_valid cyc=%0d got=%b exp=%b", c, bus64.out_valid, exp_q64.size() != 0);
      end else if (exp_q64.size() != 0) begin
        n_checks++;
        if (obs64() !== exp_q64[0]) begin
          n_fail++; $display("FAIL rnd64_entry cyc=%0d got=%h exp=%h", c, obs64(), exp_q64[0]);
        end
      end
      n_checks++;
      if (bus64.illegal_cnt !== exp_cnt64) begin
        n_fail++; $display("FAIL rnd64_cnt cyc=%0d got=%0d exp=%0d", c, bus64.illegal_cnt, exp_cnt64);
      end
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 9) == 0);
      ins  = rand_instr();
      pc   = {$urandom, $urandom};
      drive64(v, ins, pc, ordy, fl);
      #1;
      exp_rdy = !fl && ((exp_q64.size() == 0) || ordy);
      n_checks++;
      if (bus64.in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rnd64_ready cyc=%0d got=%b exp=%b", c, bus64.in_ready, exp_rdy);
      end
      if (fl) exp_q64.delete();
      else if (v && exp_rdy) begin
        e = model(ins, pc, 64);
        exp_q64.delete();
        exp_q64.push_back(e);
        if (e.illegal && exp_cnt64 != 16'hFFFF) exp_cnt64++;
      end else if (ordy) exp_q64.delete();
      @(negedge clk);
    end
    drive64(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    exp_q64.delete();
  endtask

  task automatic test_saturate();
    int exp_sat;
    for (int i = 1; i <= 5; i++) begin
      drive_sat(1'b1, 32'h0000007F, 1'b1);
      @(negedge clk);
      exp_sat = (i > 3) ? 3 : i;
      n_checks++;
      if ({bus_sat.out_fmt, bus_sat.out_illegal, bus_sat.illegal_cnt} !== {3'd7, 1'b1, 2'(exp_sat)}) begin
        n_fail++; $display("FAIL saturate[%0d] got fmt=%0d ill=%b cnt=%0d exp fmt=7 ill=1 cnt=%0d",
                           i, bus_sat.out_fmt, bus_sat.out_illegal, bus_sat.illegal_cnt, exp_sat);
      end
    end
    drive_sat(1'b0, 32'h0, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stall();
    drive32(1'b1, 32'h00A00093, 32'h80, 1'b0, 1'b0);
    @(negedge clk);
    drive32(1'b1, 32'h0000007F, 32'h84, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q32.delete(); exp_q64.delete();
    exp_cnt32 = 16'd0; exp_cnt64 = 16'd0;
    n_checks++;
    if (bus32.out_valid !== 1'b0 || obs32() !== '0) begin
      n_fail++; $display("FAIL rst_mid got v=%b obs=%h exp all 0", bus32.out_valid, obs32());
    end
    n_checks++;
    if ({bus32.illegal_cnt, bus64.illegal_cnt, bus_sat.illegal_cnt} !== 34'd0) begin
      n_fail++; $display("FAIL rst_mid_cnt got=%0d/%0d/%0d exp=0", bus32.illegal_cnt,
                         bus64.illegal_cnt, bus_sat.illegal_cnt);
    end
    drive32(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_release got rdy=%b v=%b exp rdy=1 v=0", bus32.in_ready, bus32.out_valid);
    end
    drive32(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    exp_cnt32 = 16'd0;
    exp_cnt64 = 16'd0;
    drive32(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive64(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    drive_sat(1'b0, 32'h0, 1'b1);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_addi();
    test_back_to_back();
    test_shift();
    test_stall_flush();
    test_illegal();
    test_random32(400);
    test_xlen64();
    test_random64(300);
    test_saturate();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
